// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants: default byte width, drain FSM encoding, overflow counter width.
package uart_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int OVF_W = 8;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read.
module uart_fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH = 16
)(
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_WIDTH-1:0]    rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the UART transmitter through a tx_start/tx_busy handshake.
// Define UART_TX_FIFO_OVF_EN to add the saturating ovf_count of dropped writes.
module uart_tx_fifo import uart_pkg::*; #(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH = 16
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   tx_start,
   output logic [DATA_WIDTH-1:0]  tx_data,
   input  logic                   tx_busy
`ifdef UART_TX_FIFO_OVF_EN
   ,output logic [OVF_W-1:0]      ovf_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [1:0] state;
   logic push, pop;
   logic [LW-1:0] level_nxt;
   logic [DATA_WIDTH-1:0] rd_data;
   always_comb begin
      push = wr_en && !full;
      pop = state == ST_LAUNCH && tx_busy;
      level_nxt = level + LW'(push) - LW'(pop);
   end
   uart_fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk(clk), .we(push), .waddr(wr_ptr), .wdata(wr_data), .raddr(rd_ptr), .rdata(rd_data)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
         full <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level_nxt;
         full <= level_nxt == LW'(DEPTH);
         empty <= level_nxt == '0;
      end
   end
   // The byte is only popped once the transmitter shows busy, so a late baud tick loses nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         tx_start <= 1'b0;
         tx_data <= '0;
      end else if (state == ST_IDLE && !empty && !tx_busy) begin
         tx_data <= rd_data;
         tx_start <= 1'b1;
         state <= ST_LAUNCH;
      end else if (pop) begin
         tx_start <= 1'b0;
         state <= ST_WAIT;
      end else if (state == ST_WAIT && !tx_busy) begin
         state <= ST_IDLE;
      end
   end
`ifdef UART_TX_FIFO_OVF_EN
   always_ff @(posedge clk)
      if (rst) ovf_count <= '0;
      else if (wr_en && full && ovf_count != '1) ovf_count <= ovf_count + 1'b1;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;
   logic clk = 1'b0;
   logic rst, wr_en, tx_busy, full, empty, tx_start;
   logic [7:0] wr_data, tx_data, ovf_count;
   logic [4:0] level;
   int n_tests = 0, n_fail = 0;
   logic [7:0] q[$];
   bit m_start, m_wait;
   logic [7:0] m_data;
   int m_ovf;
   bit force_busy = 0, rnd = 0;
   int dly = 3, hmax = 3, cnt = 0, left = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
      .level(level), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
`ifdef UART_TX_FIFO_OVF_EN
      , .ovf_count(ovf_count)
`endif
   );
`ifndef UART_TX_FIFO_OVF_EN
   assign ovf_count = '0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      int sz = q.size();
      bit push, pop, launch;
      if (rst) begin
         q.delete();
         m_start = 0;
         m_wait = 0;
         m_data = 0;
         m_ovf = 0;
         return;
      end
      push = wr_en && sz < DEPTH;
      pop = m_start && tx_busy;
      launch = !m_start && !m_wait && sz > 0 && !tx_busy;
      if (wr_en && sz == DEPTH && m_ovf < 255) m_ovf++;
      if (launch) begin
         m_data = q[0];
         m_start = 1;
      end else if (pop) begin
         void'(q.pop_front());
         m_start = 0;
         m_wait = 1;
      end else if (m_wait && !tx_busy) m_wait = 0;
      if (push) q.push_back(wr_data);
   endtask

   // Transmitter stand-in: answers tx_start with busy after dly cycles and holds it a while.
   task automatic xmit();
      if (rst) begin
         tx_busy = 0;
         cnt = 0;
      end else if (force_busy) tx_busy = 1;
      else if (tx_busy) begin
         if (left > 0) left--;
         else tx_busy = 0;
      end else if (tx_start) begin
         if (cnt >= dly) begin
            tx_busy = 1;
            left = $urandom_range(0, hmax);
            cnt = 0;
            if (rnd) dly = $urandom_range(0, 4);
         end else cnt++;
      end else cnt = 0;
   endtask

   task automatic cyc(input bit wr, input logic [7:0] d);
      wr_en = wr;
      wr_data = d;
      @(posedge clk);
      model_edge();
      #1;
      chk("tx_start", tx_start, m_start);
      chk("tx_data", tx_data, m_data);
      chk("level", level, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, q.size() == 0);
`ifdef UART_TX_FIFO_OVF_EN
      chk("ovf_count", ovf_count, m_ovf);
`endif
      xmit();
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || m_start || m_wait) && n < 3000) begin
         cyc(0, 8'h00);
         n++;
      end
      if (n >= 3000) chk("drain_timeout", 1, 0);
   endtask

   initial begin
      int n;
      rst = 1;
      wr_en = 0;
      wr_data = 0;
      tx_busy = 0;
      cyc(0, 0);
      cyc(0, 0);
      rst = 0;
      // single byte
      dly = 5;
      cyc(1, 8'hA5);
      repeat (20) cyc(0, 0);
      chk("single_level", level, 0);
      // burst with the transmitter slow enough that the FIFO fills
      dly = 40;
      for (int i = 1; i <= 16; i++) cyc(1, 8'(i));
      chk("burst_full", full, 1);
      dly = 2;
      drain();
      chk("burst_empty", empty, 1);
      // overflow with the transmitter stuck busy
      force_busy = 1;
      n = 0;
      while (q.size() < DEPTH && n < 100) begin
         cyc(1, 8'($urandom));
         n++;
      end
      if (n >= 100) chk("fill_timeout", 1, 0);
      repeat (3) cyc(1, 8'hEE);
`ifdef UART_TX_FIFO_OVF_EN
      chk("ovf_3", ovf_count, 3);
`endif
      repeat (260) cyc(1, 8'hDD);
`ifdef UART_TX_FIFO_OVF_EN
      chk("ovf_sat", ovf_count, 255);
`endif
      force_busy = 0;
      drain();
      // random traffic: alternating fill/drain pressure wraps the pointers many times
      rnd = 1;
      hmax = 4;
      for (int i = 0; i < 800; i++)
         cyc($urandom_range(0, 99) < (((i / 100) % 2) ? 75 : 25), 8'($urandom));
      drain();
      // reset while tx_start is held
      rnd = 0;
      dly = 30;
      for (int i = 0; i < 5; i++) cyc(1, 8'h30 + 8'(i));
      n = 0;
      while (!tx_start && n < 20) begin
         cyc(0, 0);
         n++;
      end
      chk("launch_seen", tx_start, 1);
      rst = 1;
      cyc(1, 8'h77);
      rst = 0;
      chk("rst_tx_start", tx_start, 0);
      chk("rst_empty", empty, 1);
      chk("rst_level", level, 0);
      dly = 1;
      cyc(1, 8'h5A);
      drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
